// File: rtl/switch_pkg.sv
// Shared constants and helpers for the switch conditioning block that feeds
// the Nios switches PIO.
package switch_pkg;

  localparam int SW_WIDTH        = 8;
  localparam int SW_SYNC_STAGES  = 2;
  localparam int SW_TICK_DIV     = 50000;
  localparam int SW_STABLE_TICKS = 10;

  // Minimum number of bits needed to hold 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// Debounce for one synchronised switch bit: a new level must hold for
// STABLE_TICKS consecutive prescaler ticks before it is accepted.
module switch_debounce_bit
  import switch_pkg::*;
#(
  parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic sync,
  input  logic reset_value,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic commit
);

  localparam int               CNT_W    = clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             mismatch;

  assign mismatch = sync ^ clean;
  // Combinational commit lets the top register changed alongside the pulses.
  assign commit   = mismatch & tick & (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
      clean   <= reset_value;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      rise <= commit & sync;
      fall <= commit & ~sync;
      if (!mismatch) begin
        cnt_reg <= '0;
      end else if (tick) begin
        if (cnt_reg == CNT_LAST) begin
          clean   <= sync;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/switch_debounce_sync.sv
// Synchronises and debounces raw board switches before the PIO in_port, with
// per-bit rise/fall pulses and a combined change strobe.
module switch_debounce_sync
  import switch_pkg::*;
#(
  parameter int               WIDTH        = SW_WIDTH,
  parameter int               SYNC_STAGES  = SW_SYNC_STAGES,
  parameter int               TICK_DIV     = SW_TICK_DIV,
  parameter int               STABLE_TICKS = SW_STABLE_TICKS,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed
);

  localparam int                 PRESC_W    = clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [WIDTH-1:0]   sync_reg [SYNC_STAGES];
  logic [PRESC_W-1:0] presc_reg;
  logic               tick;
  logic [WIDTH-1:0]   commit;

  // raw_in is sampled only by the first stage of this chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= RESET_VALUE;
      end
    end else begin
      sync_reg[0] <= raw_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= sync_reg[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg <= '0;
    end else if (presc_reg == PRESC_LAST) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PRESC_W'(1);
    end
  end

  assign tick = (presc_reg == PRESC_LAST);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    switch_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick       (tick),
      .sync       (sync_reg[SYNC_STAGES-1][gi]),
      .reset_value(RESET_VALUE[gi]),
      .clean      (clean_out[gi]),
      .rise       (rise_pulse[gi]),
      .fall       (fall_pulse[gi]),
      .commit     (commit[gi])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed <= 1'b0;
    end else begin
      changed <= |commit;
    end
  end

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Randomised and directed bench for switch_debounce_sync against a
// cycle-count based behavioural model.
module tb_switch_debounce_sync;

  localparam int WIDTH = 8;
  localparam int SS    = 2;
  localparam int TD    = 4;
  localparam int ST    = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] raw_in = '0;
  logic [WIDTH-1:0] clean_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic             changed;

  switch_debounce_sync #(
    .WIDTH(WIDTH), .SYNC_STAGES(SS), .TICK_DIV(TD), .STABLE_TICKS(ST),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .clean_out(clean_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .changed(changed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    n_checks++;
    if (actual < lo || actual > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Model: sync is raw delayed SS edges, a tick is every TD-th edge since
  // reset, and a bit flips after ST ticks of uninterrupted disagreement.
  logic [WIDTH-1:0] m_pipe [SS];
  int               m_cycles;
  int               m_ticks_seen [WIDTH];
  logic [WIDTH-1:0] m_clean, m_rise, m_fall;
  logic             m_changed;

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_pipe[k] = '0;
    for (int i = 0; i < WIDTH; i++) m_ticks_seen[i] = 0;
    m_cycles = 0;
    m_clean = '0; m_rise = '0; m_fall = '0; m_changed = 1'b0;
  endtask

  task automatic model_step();
    bit               is_tick;
    logic [WIDTH-1:0] s;
    is_tick = (m_cycles % TD) == TD - 1;
    s = m_pipe[SS-1];
    m_rise = '0; m_fall = '0; m_changed = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == m_clean[i]) begin
        m_ticks_seen[i] = 0;
      end else if (is_tick) begin
        m_ticks_seen[i] = m_ticks_seen[i] + 1;
        if (m_ticks_seen[i] == ST) begin
          m_clean[i] = s[i];
          m_ticks_seen[i] = 0;
          if (s[i]) m_rise[i] = 1'b1;
          else      m_fall[i] = 1'b1;
          m_changed = 1'b1;
        end
      end
    end
    for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = raw_in;
    m_cycles++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // Per-cycle compare plus event counters used by the directed tests.
  int               rise_cycles = 0, fall_cycles = 0, changed_cycles = 0, clean_changes = 0;
  logic [WIDTH-1:0] last_rise = '0, last_fall = '0, prev_clean = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("clean_out", clean_out, m_clean);
        check("rise_pulse", rise_pulse, m_rise);
        check("fall_pulse", fall_pulse, m_fall);
        check("changed", changed, m_changed);
        if (rise_pulse != 0) begin rise_cycles++; last_rise = rise_pulse; end
        if (fall_pulse != 0) begin fall_cycles++; last_fall = fall_pulse; end
        if (changed) changed_cycles++;
        if (clean_out != prev_clean) clean_changes++;
        prev_clean = clean_out;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_clean(input logic [WIDTH-1:0] target, output int n);
    n = 0;
    while (clean_out !== target && n < 60) begin
      step();
      n++;
    end
  endtask

  int n, r0, f0, c0, cc0;

  task automatic snap();
    r0 = rise_cycles; f0 = fall_cycles; c0 = changed_cycles; cc0 = clean_changes;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // 1: idle after reset
    snap();
    repeat (100) step();
    check("t1_clean", clean_out, 8'h00);
    check("t1_pulse_cycles", rise_cycles + fall_cycles - r0 - f0, 0);
    check("t1_changed_cycles", changed_cycles - c0, 0);

    // 2: single rise launched just after a tick
    for (int k = 0; k < TD + 1 && (m_cycles % TD) != 0; k++) step();
    snap();
    raw_in = 8'h01;
    wait_clean(8'h01, n);
    check_range("t2_latency", n, 11, 14);
    repeat (4) step();
    check("t2_rise_cycles", rise_cycles - r0, 1);
    check("t2_rise_value", last_rise, 8'h01);
    check("t2_changed_cycles", changed_cycles - c0, 1);
    check("t2_fall_cycles", fall_cycles - f0, 0);

    // 3: bounce then settle high
    raw_in = 8'h00;
    wait_clean(8'h00, n);
    repeat (3) step();
    snap();
    for (int b = 0; b < 4; b++) begin
      raw_in = (b % 2 == 0) ? 8'h01 : 8'h00;
      repeat (3) step();
    end
    check("t3_no_change_during_bounce", clean_changes - cc0, 0);
    raw_in = 8'h01;
    wait_clean(8'h01, n);
    check_range("t3_settle_latency", n, 11, 14);
    repeat (4) step();
    check("t3_rise_cycles", rise_cycles - r0, 1);
    check("t3_clean_changes", clean_changes - cc0, 1);

    // 4: simultaneous fall of the upper nibble
    raw_in = 8'hFF;
    wait_clean(8'hFF, n);
    repeat (3) step();
    snap();
    raw_in = 8'h0F;
    wait_clean(8'h0F, n);
    repeat (4) step();
    check("t4_clean", clean_out, 8'h0F);
    check("t4_fall_cycles", fall_cycles - f0, 1);
    check("t4_fall_value", last_fall, 8'hF0);
    check("t4_changed_cycles", changed_cycles - c0, 1);
    check("t4_rise_cycles", rise_cycles - r0, 0);

    // 5: 2-cycle glitch on bit7
    snap();
    raw_in = 8'h8F;
    repeat (2) step();
    raw_in = 8'h0F;
    repeat (40) step();
    check("t5_clean", clean_out, 8'h0F);
    check("t5_clean_changes", clean_changes - cc0, 0);
    check("t5_changed_cycles", changed_cycles - c0, 0);

    // 6: reset while bit3 is part way through qualification
    raw_in = 8'h03;
    wait_clean(8'h03, n);
    repeat (3) step();
    raw_in = 8'h0B;
    for (int k = 0; k < 40 && m_ticks_seen[3] != 2; k++) step();
    check("t6_bit3_partial_ticks", m_ticks_seen[3], 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_clean_in_reset", clean_out, 8'h00);
    check("t6_rise_in_reset", rise_pulse, 8'h00);
    check("t6_changed_in_reset", changed, 0);
    raw_in = 8'h08;
    repeat (3) step();
    reset_n = 1'b1;
    snap();
    wait_clean(8'h08, n);
    check_range("t6_requalify_latency", n, 11, 14);
    repeat (4) step();
    check("t6_rise_cycles", rise_cycles - r0, 1);
    check("t6_rise_value", last_rise, 8'h08);

    // Random levels and hold times, covered by the per-cycle compare
    for (int t = 0; t < 60; t++) begin
      raw_in = WIDTH'($urandom);
      repeat ($urandom_range(1, 20)) step();
    end
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
